// File: rtl/wbi_pkg.sv
// Shared types and helpers for the wbi command scheduler.
package wbi_pkg;

   typedef enum logic [1:0] {IDLE, LOCK_M, LOCK_P} sched_state_t;

   localparam logic SRC_M = 1'b0;
   localparam logic SRC_P = 1'b1;

   // Reads are always one beat; a write with bl==0 still carries one beat.
   function automatic logic [15:0] beats(input logic we, input logic [15:0] bl);
      if (!we || bl == '0) return 16'd1;
      return bl;
   endfunction

endpackage

// File: rtl/wbi_outs_cnt.sv
// Up/down outstanding-transaction counter with full flag; saturates at 0 and MAX_OUTS.
module wbi_outs_cnt #(
   parameter int unsigned MAX_OUTS = 4,
   parameter int unsigned OW       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full
);

   logic [OW-1:0] cnt;

   assign full = (cnt == OW'(MAX_OUTS));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && !dec && !full) begin
         cnt <= cnt + OW'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - OW'(1);
      end
   end

endmodule

// File: rtl/wbi_cmd_sched.sv
// Command-slot scheduler: round-robin M/P arbitration with write-burst lock and
// local outstanding limit. Optional statistics counters under WBI_SCHED_STATS_EN.
module wbi_cmd_sched
   import wbi_pkg::*;
#(
   parameter int unsigned BL       = 10,
   parameter int unsigned MAX_OUTS = 4,
   parameter int unsigned OW       = 4
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          m_cmd_val_i,
   input  logic          m_cmd_we_i,
   input  logic [BL-1:0] m_cmd_bl_i,
   input  logic          p_cmd_val_i,
   input  logic          p_cmd_we_i,
   input  logic [BL-1:0] p_cmd_bl_i,
   input  logic          stg_cmd_wrdy_i,
   input  logic          m_res_lfire_i,
   output logic          gnt_o,
   output logic          m_cmd_en_o,
   output logic          p_cmd_en_o,
   output logic          lock_o,
   output logic          m_outs_full_o,
   output logic [15:0]   stat_m_cnt_o,
   output logic [15:0]   stat_p_cnt_o
);

   sched_state_t  state, state_nxt;
   logic          gnt_q;
   logic          rr_ptr, rr_nxt;
   logic [BL-1:0] beat_cnt, beat_nxt;
   logic          m_req, p_req, fire, multi, outs_inc;
   logic          cmd_we;
   logic [BL-1:0] cmd_bl;

   assign m_req      = m_cmd_val_i & ~m_outs_full_o;
   assign p_req      = p_cmd_val_i;
   assign lock_o     = (state != IDLE);
   assign m_cmd_en_o = ~gnt_o & (lock_o | ~m_outs_full_o);
   assign p_cmd_en_o = gnt_o;
   // Through m_cmd_en_o the outstanding limit gates only the first M beat.
   assign fire       = stg_cmd_wrdy_i & (gnt_o ? p_cmd_val_i : (m_cmd_val_i & m_cmd_en_o));
   assign cmd_we     = gnt_o ? p_cmd_we_i : m_cmd_we_i;
   assign cmd_bl     = gnt_o ? p_cmd_bl_i : m_cmd_bl_i;
   assign multi      = (beats(cmd_we, 16'(cmd_bl)) > 16'd1);

   always_comb begin
      gnt_o = gnt_q;
      unique case (state)
         IDLE: begin
            if (m_req && p_req) gnt_o = ~rr_ptr;
            else if (m_req)     gnt_o = SRC_M;
            else if (p_req)     gnt_o = SRC_P;
         end
         LOCK_M:  gnt_o = SRC_M;
         LOCK_P:  gnt_o = SRC_P;
         default: gnt_o = gnt_q;
      endcase
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      beat_nxt  = beat_cnt;
      outs_inc  = 1'b0;
      if (fire) begin
         unique case (state)
            IDLE: begin
               if (multi) begin
                  beat_nxt  = cmd_bl - BL'(1);
                  state_nxt = gnt_o ? LOCK_P : LOCK_M;
               end else begin
                  rr_nxt   = gnt_o;
                  outs_inc = (gnt_o == SRC_M);
               end
            end
            LOCK_M, LOCK_P: begin
               beat_nxt = beat_cnt - BL'(1);
               if (beat_cnt == BL'(1)) begin
                  state_nxt = IDLE;
                  rr_nxt    = gnt_o;
                  outs_inc  = (gnt_o == SRC_M);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state    <= IDLE;
         gnt_q    <= SRC_M;
         rr_ptr   <= SRC_P;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt_q    <= gnt_o;
         rr_ptr   <= rr_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   wbi_outs_cnt #(
      .MAX_OUTS (MAX_OUTS),
      .OW       (OW)
   ) u_outs_cnt (
      .clk   (mclk),
      .reset (reset),
      .inc   (outs_inc),
      .dec   (m_res_lfire_i),
      .full  (m_outs_full_o)
   );

`ifdef WBI_SCHED_STATS_EN
   logic        first_fire;
   logic [15:0] stat_m_q, stat_p_q;

   assign first_fire   = fire & (state == IDLE);
   assign stat_m_cnt_o = stat_m_q;
   assign stat_p_cnt_o = stat_p_q;

   always_ff @(posedge mclk) begin
      if (reset) begin
         stat_m_q <= '0;
         stat_p_q <= '0;
      end else if (first_fire) begin
         if (gnt_o == SRC_M && stat_m_q != '1) stat_m_q <= stat_m_q + 16'd1;
         if (gnt_o == SRC_P && stat_p_q != '1) stat_p_q <= stat_p_q + 16'd1;
      end
   end
`else
   assign stat_m_cnt_o = '0;
   assign stat_p_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wbi_cmd_sched.sv
// Directed self-checking bench for wbi_cmd_sched (default parameters).
module tb_wbi_cmd_sched;

   logic        mclk = 1'b0;
   logic        reset;
   logic        m_cmd_val_i, m_cmd_we_i;
   logic [9:0]  m_cmd_bl_i;
   logic        p_cmd_val_i, p_cmd_we_i;
   logic [9:0]  p_cmd_bl_i;
   logic        stg_cmd_wrdy_i, m_res_lfire_i;
   logic        gnt_o, m_cmd_en_o, p_cmd_en_o, lock_o, m_outs_full_o;
   logic [15:0] stat_m_cnt_o, stat_p_cnt_o;

   int total = 0;
   int bad   = 0;

`ifdef WBI_SCHED_STATS_EN
   localparam int EXP_STAT_M = 3;
   localparam int EXP_STAT_P = 2;
`else
   localparam int EXP_STAT_M = 0;
   localparam int EXP_STAT_P = 0;
`endif

   wbi_cmd_sched #(
      .BL       (10),
      .MAX_OUTS (4),
      .OW       (4)
   ) dut (
      .mclk           (mclk),
      .reset          (reset),
      .m_cmd_val_i    (m_cmd_val_i),
      .m_cmd_we_i     (m_cmd_we_i),
      .m_cmd_bl_i     (m_cmd_bl_i),
      .p_cmd_val_i    (p_cmd_val_i),
      .p_cmd_we_i     (p_cmd_we_i),
      .p_cmd_bl_i     (p_cmd_bl_i),
      .stg_cmd_wrdy_i (stg_cmd_wrdy_i),
      .m_res_lfire_i  (m_res_lfire_i),
      .gnt_o          (gnt_o),
      .m_cmd_en_o     (m_cmd_en_o),
      .p_cmd_en_o     (p_cmd_en_o),
      .lock_o         (lock_o),
      .m_outs_full_o  (m_outs_full_o),
      .stat_m_cnt_o   (stat_m_cnt_o),
      .stat_p_cnt_o   (stat_p_cnt_o)
   );

   always #5 mclk = ~mclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic mcmd(input logic val, input logic we, input logic [9:0] bl);
      m_cmd_val_i = val;
      m_cmd_we_i  = we;
      m_cmd_bl_i  = bl;
   endtask

   task automatic pcmd(input logic val, input logic we, input logic [9:0] bl);
      p_cmd_val_i = val;
      p_cmd_we_i  = we;
      p_cmd_bl_i  = bl;
   endtask

   task automatic do_reset();
      mcmd(1'b0, 1'b0, 10'd0);
      pcmd(1'b0, 1'b0, 10'd0);
      stg_cmd_wrdy_i = 1'b0;
      m_res_lfire_i  = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_gnt",    gnt_o,         0);
      chk("rst_lock",   lock_o,        0);
      chk("rst_full",   m_outs_full_o, 0);
      chk("rst_m_en",   m_cmd_en_o,    1);
      chk("rst_p_en",   p_cmd_en_o,    0);
      chk("rst_stat_m", stat_m_cnt_o,  0);
      chk("rst_stat_p", stat_p_cnt_o,  0);

      // 1: both sides stream reads -> strict alternation starting with M
      mcmd(1'b1, 1'b0, 10'd0);
      pcmd(1'b1, 1'b0, 10'd0);
      stg_cmd_wrdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t1_gnt",  gnt_o,      i & 1);
         chk("t1_p_en", p_cmd_en_o, i & 1);
         tick();
      end

      // 2: M write bl=4 holds the slot against a valid P
      do_reset();
      mcmd(1'b1, 1'b1, 10'd4);
      pcmd(1'b1, 1'b0, 10'd0);
      stg_cmd_wrdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_gnt_m", gnt_o, 0);
         tick();
         chk("t2_lock", lock_o, (i < 3) ? 1 : 0);
      end
      #1;
      chk("t2_gnt_p", gnt_o, 1);
      tick();

      // 3: LOCK_P bl=3 stalled by ready low for 5 cycles
      do_reset();
      pcmd(1'b1, 1'b1, 10'd3);
      stg_cmd_wrdy_i = 1'b1;
      #1;
      chk("t3_gnt_p", gnt_o, 1);
      tick();
      chk("t3_lock_b1", lock_o, 1);
      stg_cmd_wrdy_i = 1'b0;
      mcmd(1'b1, 1'b0, 10'd0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_stall_gnt",  gnt_o,      1);
         chk("t3_stall_m_en", m_cmd_en_o, 0);
         tick();
         chk("t3_stall_lock", lock_o, 1);
      end
      stg_cmd_wrdy_i = 1'b1;
      tick();
      chk("t3_lock_b2", lock_o, 1);
      tick();
      chk("t3_lock_b3", lock_o, 0);
      #1;
      chk("t3_rr_to_m", gnt_o, 0);
      tick();

      // 4: outstanding limit, release by lack, simultaneous inc/dec
      do_reset();
      m_res_lfire_i = 1'b1;
      tick();
      m_res_lfire_i = 1'b0;
      mcmd(1'b1, 1'b0, 10'd0);
      stg_cmd_wrdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_fill", m_outs_full_o, (i == 3) ? 1 : 0);
      end
      #1;
      chk("t4_m_en_blk", m_cmd_en_o, 0);
      pcmd(1'b1, 1'b0, 10'd0);
      #1;
      chk("t4_p_served", gnt_o, 1);
      tick();
      pcmd(1'b0, 1'b0, 10'd0);
      m_res_lfire_i = 1'b1;
      #1;
      chk("t4_hold_gnt", gnt_o, 1);
      tick();
      m_res_lfire_i = 1'b0;
      chk("t4_full_dec", m_outs_full_o, 0);
      #1;
      chk("t4_m_gnt",  gnt_o,      0);
      chk("t4_m_en",   m_cmd_en_o, 1);
      m_res_lfire_i = 1'b1;
      tick();
      m_res_lfire_i = 1'b0;
      chk("t4_incdec", m_outs_full_o, 0);
      tick();
      chk("t4_refill", m_outs_full_o, 1);

      // 5: reset during the second beat of an M bl=8 write
      do_reset();
      mcmd(1'b1, 1'b0, 10'd0);
      stg_cmd_wrdy_i = 1'b1;
      tick();
      tick();
      mcmd(1'b1, 1'b1, 10'd8);
      tick();
      chk("t5_locked", lock_o, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mcmd(1'b0, 1'b0, 10'd0);
      chk("t5_lock",  lock_o,        0);
      #1;
      chk("t5_gnt",   gnt_o,         0);
      chk("t5_full",  m_outs_full_o, 0);
      mcmd(1'b1, 1'b0, 10'd0);
      tick();
      chk("t5_noresume", lock_o, 0);
      tick();
      tick();
      chk("t5_outs3", m_outs_full_o, 0);
      tick();
      chk("t5_outs4", m_outs_full_o, 1);

      // 6: statistics (3 M, 2 P transactions), bl=0 write is single-beat
      do_reset();
      stg_cmd_wrdy_i = 1'b1;
      mcmd(1'b1, 1'b0, 10'd0);
      tick();
      mcmd(1'b0, 1'b0, 10'd0);
      pcmd(1'b1, 1'b1, 10'd0);
      #1;
      chk("t6_gnt_p", gnt_o, 1);
      tick();
      chk("t6_bl0", lock_o, 0);
      pcmd(1'b0, 1'b0, 10'd0);
      mcmd(1'b1, 1'b1, 10'd4);
      tick();
      chk("t6_lock", lock_o, 1);
      tick();
      tick();
      tick();
      chk("t6_unlock", lock_o, 0);
      mcmd(1'b0, 1'b0, 10'd0);
      pcmd(1'b1, 1'b0, 10'd0);
      tick();
      pcmd(1'b0, 1'b0, 10'd0);
      mcmd(1'b1, 1'b0, 10'd0);
      tick();
      mcmd(1'b0, 1'b0, 10'd0);
      tick();
      chk("t6_stat_m", stat_m_cnt_o, EXP_STAT_M);
      chk("t6_stat_p", stat_p_cnt_o, EXP_STAT_P);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
